// File: rtl/alu_multicycle.sv
// Execute-stage ALU with single-cycle integer ops and iterative RV64M multiply/divide.
// Operands are accepted and results are delivered through valid/ready handshakes.
module alu_multicycle #(
    parameter int XLEN       = 64,
    parameter int MUL_UNROLL = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic [3:0]      func_control,
    input  logic [3:0]      inner_control,
    input  logic            word_op,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result_out,
    output logic            busy
);

    // Handshake: an op transfers in when in_valid && in_ready, a result transfers out when
    // out_valid && out_ready; flush drops both ready and valid so neither transfer happens.
    localparam logic [3:0] FUNC_ADD   = 4'd0;
    localparam logic [3:0] FUNC_SHIFT = 4'd1;
    localparam logic [3:0] FUNC_CMP   = 4'd2;
    localparam logic [3:0] FUNC_DIV   = 4'd3;
    localparam logic [3:0] FUNC_LOGIC = 4'd4;
    localparam logic [3:0] FUNC_MUL   = 4'd5;
    localparam logic [3:0] FUNC_AUIPC = 4'd6;
    localparam logic [3:0] FUNC_LUI   = 4'd7;

    localparam bit WORD_OK = (XLEN == 64);
    localparam int SH_W    = $clog2(XLEN);
    localparam int CNT_W   = $clog2(XLEN + 1);
    localparam logic [CNT_W-1:0] MUL_CYCLES = CNT_W'(XLEN / MUL_UNROLL);
    localparam logic [CNT_W-1:0] DIV_CYCLES = CNT_W'(XLEN);
    localparam logic [XLEN-1:0]  MIN_VAL    = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    function automatic logic [XLEN-1:0] extend32(input logic [XLEN-1:0] v, input logic sgn);
        logic [XLEN-1:0] r;
        r = v;
        for (int i = 32; i < XLEN; i++) begin
            r[i] = sgn & v[31];
        end
        return r;
    endfunction

    // Shift-add over the low half: each step conditionally adds the multiplicand to the
    // upper half and shifts the whole product right by one.
    function automatic logic [2*XLEN-1:0] mul_step(input logic [2*XLEN-1:0] p,
                                                   input logic [XLEN-1:0]   m);
        logic [XLEN:0]     hi;
        logic [2*XLEN-1:0] r;
        r = p;
        for (int i = 0; i < MUL_UNROLL; i++) begin
            hi = {1'b0, r[2*XLEN-1:XLEN]} + (r[0] ? {1'b0, m} : {(XLEN+1){1'b0}});
            r  = {hi, r[XLEN-1:1]};
        end
        return r;
    endfunction

    // Restoring step on {remainder, dividend}: shift left, subtract when it fits.
    function automatic logic [2*XLEN-1:0] div_step(input logic [2*XLEN-1:0] p,
                                                   input logic [XLEN-1:0]   d);
        logic [XLEN:0]   t;
        logic [XLEN-1:0] lo;
        t  = {p[2*XLEN-1:XLEN], p[XLEN-1]};
        lo = {p[XLEN-2:0], 1'b0};
        if (t >= {1'b0, d}) begin
            t     = t - {1'b0, d};
            lo[0] = 1'b1;
        end
        return {t[XLEN-1:0], lo};
    endfunction

    logic              accept;
    logic              word_en;
    logic              sign1, sign2;
    logic [XLEN-1:0]   op1, op2;
    logic [SH_W-1:0]   shamt;
    logic              div_zero, div_ovf;
    logic              is_mul, is_div_iter, start_iter;
    logic              a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [XLEN-1:0]   quick_res;

    logic [2*XLEN-1:0] work_q, work_next;
    logic [XLEN-1:0]   opnd_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              mul_q, word_q, neg_q, rneg_q;
    logic [1:0]        inner_q;
    logic [XLEN-1:0]   result_q;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix;
    logic [XLEN-1:0]   fin_res;

    assign accept  = in_valid && in_ready;
    assign word_en = WORD_OK && word_op;

    // Unsigned sub-ops zero-extend their word operands; everything else sign-extends.
    always_comb begin
        sign1 = 1'b1;
        sign2 = 1'b1;
        case (func_control)
            FUNC_SHIFT: sign1 = (inner_control != 4'd1);
            FUNC_CMP: begin
                sign1 = (inner_control != 4'd1);
                sign2 = (inner_control != 4'd1);
            end
            FUNC_DIV: begin
                sign1 = !inner_control[0];
                sign2 = !inner_control[0];
            end
            FUNC_MUL: begin
                sign1 = (inner_control != 4'd3);
                sign2 = (inner_control != 4'd2) && (inner_control != 4'd3);
            end
            default: ;
        endcase
    end

    always_comb begin
        op1   = src1;
        op2   = src2;
        shamt = src2[SH_W-1:0];
        if (word_en) begin
            op1   = extend32(src1, sign1);
            op2   = extend32(src2, sign2);
            shamt = SH_W'(src2[4:0]);
        end
    end

    assign div_zero = (op2 == '0);
    assign div_ovf  = !inner_control[0] &&
                      (word_en ? (src1[31:0] == 32'h8000_0000 && src2[31:0] == 32'hFFFF_FFFF)
                               : (op1 == MIN_VAL && op2 == '1));

    assign is_mul      = (func_control == FUNC_MUL) && (inner_control < 4'd4);
    assign is_div_iter = (func_control == FUNC_DIV) && (inner_control < 4'd4) &&
                         !div_zero && !div_ovf;
    assign start_iter  = is_mul || is_div_iter;

    assign a_neg = sign1 && op1[XLEN-1];
    assign b_neg = sign2 && op2[XLEN-1];
    assign a_mag = a_neg ? (~op1 + XLEN'(1)) : op1;
    assign b_mag = b_neg ? (~op2 + XLEN'(1)) : op2;

    always_comb begin
        quick_res = '0;
        case (func_control)
            FUNC_ADD: begin
                if (inner_control == 4'd0)      quick_res = op1 + op2;
                else if (inner_control == 4'd1) quick_res = op1 - op2;
            end
            FUNC_SHIFT: begin
                if (inner_control == 4'd0)      quick_res = op1 << shamt;
                else if (inner_control == 4'd1) quick_res = op1 >> shamt;
                else if (inner_control == 4'd2) quick_res = $signed(op1) >>> shamt;
            end
            FUNC_CMP: begin
                if (inner_control == 4'd0)
                    quick_res = {{(XLEN-1){1'b0}}, ($signed(op1) < $signed(op2))};
                else if (inner_control == 4'd1)
                    quick_res = {{(XLEN-1){1'b0}}, (op1 < op2)};
            end
            FUNC_LOGIC: begin
                if (inner_control == 4'd0)      quick_res = op1 & op2;
                else if (inner_control == 4'd1) quick_res = op1 | op2;
                else if (inner_control == 4'd2) quick_res = op1 ^ op2;
            end
            FUNC_DIV: begin
                if (inner_control < 4'd4) begin
                    if (div_zero)     quick_res = inner_control[1] ? op1 : '1;
                    else if (div_ovf) quick_res = inner_control[1] ? '0 : op1;
                end
            end
            FUNC_AUIPC: quick_res = op1 + op2;
            FUNC_LUI:   quick_res = op2;
            default: ;
        endcase
        if (word_en) quick_res = extend32(quick_res, 1'b1);
    end

    assign work_next = mul_q ? mul_step(work_q, opnd_q) : div_step(work_q, opnd_q);
    assign prod_fix  = neg_q ? (~work_next + (2*XLEN)'(1)) : work_next;
    assign quo_fix   = neg_q ? (~work_next[XLEN-1:0] + XLEN'(1)) : work_next[XLEN-1:0];
    assign rem_fix   = rneg_q ? (~work_next[2*XLEN-1:XLEN] + XLEN'(1))
                              : work_next[2*XLEN-1:XLEN];

    always_comb begin
        fin_res = '0;
        if (mul_q) begin
            fin_res = (inner_q == 2'd0) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        end else begin
            fin_res = inner_q[1] ? rem_fix : quo_fix;
        end
        if (word_q) fin_res = extend32(fin_res, 1'b1);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = start_iter ? S_CALC : S_DONE;
            S_CALC: if (cnt_q == CNT_W'(1)) state_d = S_DONE;
            S_DONE: begin
                if (accept)         state_d = start_iter ? S_CALC : S_DONE;
                else if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (flush) state_d = S_IDLE;
    end

    // Output logic.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            S_IDLE: in_ready = 1'b1;
            S_CALC: busy = 1'b1;
            S_DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
            end
            default: ;
        endcase
        if (flush) begin
            in_ready  = 1'b0;
            out_valid = 1'b0;
        end
    end

    // Datapath: capture at accept, iterate in CALC, latch the final result on the last step.
    always_ff @(posedge clk) begin
        if (rst) begin
            work_q   <= '0;
            opnd_q   <= '0;
            cnt_q    <= '0;
            mul_q    <= 1'b0;
            word_q   <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            inner_q  <= 2'd0;
            result_q <= '0;
        end else if (flush) begin
            cnt_q <= '0;
        end else if (accept) begin
            mul_q   <= is_mul;
            word_q  <= word_en;
            inner_q <= inner_control[1:0];
            if (is_mul) begin
                work_q <= {{XLEN{1'b0}}, b_mag};
                opnd_q <= a_mag;
                neg_q  <= a_neg ^ b_neg;
                rneg_q <= 1'b0;
                cnt_q  <= MUL_CYCLES;
            end else if (is_div_iter) begin
                work_q <= {{XLEN{1'b0}}, a_mag};
                opnd_q <= b_mag;
                neg_q  <= a_neg ^ b_neg;
                rneg_q <= a_neg;
                cnt_q  <= DIV_CYCLES;
            end else begin
                result_q <= quick_res;
            end
        end else if (state_q == S_CALC) begin
            work_q <= work_next;
            cnt_q  <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) result_q <= fin_res;
        end
    end

    assign result_out = result_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle: directed corner cases plus a randomized stream
// with random backpressure, compared against a plain-arithmetic reference model.
module tb_alu_multicycle;

    localparam int MUL_U   = 1;
    localparam int MUL_LAT = 64 / MUL_U + 1;
    localparam int DIV_LAT = 65;
    localparam int N_RAND  = 80;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, word_op, out_valid, out_ready, busy;
    logic [63:0] src1, src2, result_out;
    logic [3:0]  func_control, inner_control;

    int n_checks = 0;
    int n_errors = 0;

    logic [63:0] exp_q[$];
    int          lat_q[$];

    alu_multicycle #(.XLEN(64), .MUL_UNROLL(MUL_U)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .src1(src1), .src2(src2), .func_control(func_control), .inner_control(inner_control),
        .word_op(word_op), .out_valid(out_valid), .out_ready(out_ready),
        .result_out(result_out), .busy(busy)
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #900_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model
    function automatic logic [63:0] ref_alu(input logic [3:0] f, input logic [3:0] i,
                                            input logic w, input logic [63:0] a,
                                            input logic [63:0] b);
        logic [63:0]        r;
        logic [31:0]        r32, a32, b32;
        logic signed [63:0] sa, sb, sq;
        logic signed [31:0] sa32, sb32, sq32;
        logic [127:0]       pa, pb, pp;
        logic [63:0]        q, rm;
        logic [31:0]        q32, rm32;
        int                 sh;
        r = '0; r32 = '0;
        a32 = a[31:0]; b32 = b[31:0];
        sa = a; sb = b; sa32 = a32; sb32 = b32;
        if (w) begin
            case (f)
                4'd0: if (i == 0) r32 = a32 + b32; else if (i == 1) r32 = a32 - b32;
                4'd1: begin
                    sh = int'(b[4:0]);
                    if (i == 0) r32 = a32 << sh;
                    else if (i == 1) r32 = a32 >> sh;
                    else if (i == 2) r32 = sa32 >>> sh;
                end
                4'd5: if (i == 0) r32 = a32 * b32;
                4'd3: if (i < 4) begin
                    if (b32 == 0) begin q32 = '1; rm32 = a32; end
                    else if (!i[0] && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
                        q32 = a32; rm32 = 0;
                    end else if (!i[0]) begin
                        sq32 = sa32 / sb32; q32 = sq32;
                        sq32 = sa32 % sb32; rm32 = sq32;
                    end else begin
                        q32 = a32 / b32; rm32 = a32 % b32;
                    end
                    r32 = i[1] ? rm32 : q32;
                end
                default: ;
            endcase
            r = {{32{r32[31]}}, r32};
        end else begin
            case (f)
                4'd0: if (i == 0) r = a + b; else if (i == 1) r = a - b;
                4'd1: begin
                    sh = int'(b[5:0]);
                    if (i == 0) r = a << sh;
                    else if (i == 1) r = a >> sh;
                    else if (i == 2) r = sa >>> sh;
                end
                4'd2: if (i == 0) r = (sa < sb) ? 64'd1 : 64'd0;
                      else if (i == 1) r = (a < b) ? 64'd1 : 64'd0;
                4'd4: if (i == 0) r = a & b; else if (i == 1) r = a | b;
                      else if (i == 2) r = a ^ b;
                4'd5: if (i < 4) begin
                    pa = {{64{(i != 3) && a[63]}}, a};
                    pb = {{64{(i < 2) && b[63]}}, b};
                    pp = pa * pb;
                    r  = (i == 0) ? pp[63:0] : pp[127:64];
                end
                4'd3: if (i < 4) begin
                    if (b == 0) begin q = '1; rm = a; end
                    else if (!i[0] && a == 64'h8000_0000_0000_0000 && b == '1) begin
                        q = a; rm = 0;
                    end else if (!i[0]) begin
                        sq = sa / sb; q = sq;
                        sq = sa % sb; rm = sq;
                    end else begin
                        q = a / b; rm = a % b;
                    end
                    r = i[1] ? rm : q;
                end
                4'd6: r = a + b;
                4'd7: r = b;
                default: ;
            endcase
        end
        return r;
    endfunction

    function automatic int ref_lat(input logic [3:0] f, input logic [3:0] i, input logic w,
                                   input logic [63:0] a, input logic [63:0] b);
        logic zero, ovf;
        if (f == 4'd5 && i < 4) return MUL_LAT;
        if (f == 4'd3 && i < 4) begin
            zero = w ? (b[31:0] == 0) : (b == 0);
            ovf  = !i[0] && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                               : (a == 64'h8000_0000_0000_0000 && b == '1));
            return (zero || ovf) ? 1 : DIV_LAT;
        end
        return 1;
    endfunction

    function automatic logic [63:0] rand_operand();
        case ($urandom_range(0, 7))
            0: return 64'd0;
            1: return 64'hFFFF_FFFF_FFFF_FFFF;
            2: return 64'h8000_0000_0000_0000;
            3: return 64'h0000_0000_8000_0000;
            4: return 64'($urandom_range(0, 20));
            5: return 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 20));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // Driver tasks
    task automatic drive_op(input logic [3:0] f, input logic [3:0] i, input logic w,
                            input logic [63:0] a, input logic [63:0] b);
        func_control = f; inner_control = i; word_op = w; src1 = a; src2 = b;
        in_valid = 1'b1;
    endtask

    task automatic run_op(input string tag, input logic [3:0] f, input logic [3:0] i,
                          input logic w, input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp_res, input int exp_lat, input int exp_busy);
        int lat, busy_n;
        @(negedge clk);
        out_ready = 1'b1;
        drive_op(f, i, w, a, b);
        #1 check({tag, "_in_ready"}, in_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1; busy_n = 0;
        #1;
        while (!out_valid && lat < 200) begin
            if (busy) busy_n++;
            @(negedge clk);
            #1 lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_result"}, result_out, exp_res);
        if (exp_busy >= 0) check({tag, "_busy_cycles"}, 64'(busy_n), 64'(exp_busy));
        @(posedge clk);
    endtask

    initial begin
        logic [63:0] held;
        logic        seen;
        logic [3:0]  f, i;
        logic        w, pending;
        logic [63:0] a, b;
        int          cyc, acc_cyc, sent;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        src1 = '0; src2 = '0; func_control = '0; inner_control = '0; word_op = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_result", result_out, 64'd0);
        check("reset_busy", busy, 1'b0);
        check("reset_in_ready", in_ready, 1'b1);

        // Back-to-back add then sub with no bubble
        @(negedge clk);
        drive_op(4'd0, 4'd0, 1'b0, 64'd5, 64'd7);
        @(posedge clk);
        @(negedge clk);
        drive_op(4'd0, 4'd1, 1'b0, 64'd3, 64'd5);
        #1;
        check("b2b_add_valid", out_valid, 1'b1);
        check("b2b_add_result", result_out, 64'd12);
        check("b2b_in_ready", in_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("b2b_sub_valid", out_valid, 1'b1);
        check("b2b_sub_result", result_out, 64'hFFFF_FFFF_FFFF_FFFE);
        @(posedge clk);

        run_op("mulh", 4'd5, 4'd1, 1'b0, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, MUL_LAT, MUL_LAT - 1);
        run_op("div_by0", 4'd3, 4'd0, 1'b0, 64'd100, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0);
        run_op("rem_by0", 4'd3, 4'd2, 1'b0, 64'd100, 64'd0, 64'd100, 1, 0);
        run_op("div_ovf", 4'd3, 4'd0, 1'b0, 64'h8000_0000_0000_0000, '1,
               64'h8000_0000_0000_0000, 1, 0);
        run_op("rem_ovf", 4'd3, 4'd2, 1'b0, 64'h8000_0000_0000_0000, '1, 64'd0, 1, 0);
        run_op("divw", 4'd3, 4'd0, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2,
               64'hFFFF_FFFF_FFFF_FFFD, DIV_LAT, DIV_LAT - 1);
        run_op("remw", 4'd3, 4'd2, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2,
               64'hFFFF_FFFF_FFFF_FFFF, DIV_LAT, -1);
        run_op("sraw", 4'd1, 4'd2, 1'b1, 64'h0000_0000_8000_0000, 64'd4,
               64'hFFFF_FFFF_F800_0000, 1, 0);
        run_op("divu_long", 4'd3, 4'd1, 1'b0, 64'd1000, 64'd7, 64'd142, DIV_LAT, -1);

        // Backpressure: result held while out_ready is low
        @(negedge clk);
        out_ready = 1'b0;
        drive_op(4'd4, 4'd2, 1'b0, 64'hF0F0, 64'h0FF0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        #1 held = result_out;
        check("bp_first_result", held, 64'hFF00);
        for (int k = 0; k < 10; k++) begin
            check("bp_valid_held", out_valid, 1'b1);
            check("bp_result_held", result_out, 64'hFF00);
            check("bp_in_ready_low", in_ready, 1'b0);
            @(negedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);

        // Flush 20 cycles into a divide; a simultaneous in_valid must be ignored
        @(negedge clk);
        drive_op(4'd3, 4'd0, 1'b0, 64'd1000, 64'd7);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (19) @(negedge clk);
        flush = 1'b1;
        drive_op(4'd0, 4'd0, 1'b0, 64'd1, 64'd1);
        #1;
        check("flush_in_ready_low", in_ready, 1'b0);
        check("flush_busy_before", busy, 1'b1);
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        #1;
        check("flush_in_ready_after", in_ready, 1'b1);
        check("flush_busy_after", busy, 1'b0);
        seen = 1'b0;
        for (int k = 0; k < 80; k++) begin
            if (out_valid) seen = 1'b1;
            @(negedge clk);
            #1;
        end
        check("flush_no_out_valid", seen, 1'b0);

        // Reset in the middle of a multiply discards it
        @(negedge clk);
        drive_op(4'd5, 4'd0, 1'b0, 64'd9, 64'd9);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_busy", busy, 1'b0);
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_result", result_out, 64'd0);
        check("midrst_in_ready", in_ready, 1'b1);

        // Randomized stream with random backpressure against the reference model
        pending = 1'b0; sent = 0; cyc = 0; acc_cyc = 0; seen = 1'b0;
        f = '0; i = '0; w = 1'b0; a = '0; b = '0;
        while ((sent < N_RAND || pending || exp_q.size() != 0) && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            out_ready = ($urandom_range(0, 3) != 0);
            if (!pending) begin
                in_valid = 1'b0;
                if (sent < N_RAND && $urandom_range(0, 1) == 1) begin
                    f = 4'($urandom_range(0, 8));
                    i = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(4, 6))
                                                    : 4'($urandom_range(0, 3));
                    w = ((f == 4'd0) || (f == 4'd1) || (f == 4'd3) || (f == 4'd5 && i == 4'd0))
                        && ($urandom_range(0, 1) == 1);
                    a = rand_operand();
                    b = rand_operand();
                    drive_op(f, i, w, a, b);
                    pending = 1'b1;
                end
            end
            #1;
            if (out_valid && !seen) begin
                seen = 1'b1;
                if (lat_q.size() != 0) check("rand_latency", 64'(cyc - acc_cyc), 64'(lat_q[0]));
                else check("rand_spurious_valid", out_valid, 1'b0);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() != 0) begin
                    check("rand_result", result_out, exp_q.pop_front());
                    void'(lat_q.pop_front());
                end else begin
                    check("rand_unexpected_result", out_valid, 1'b0);
                end
                seen = 1'b0;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_alu(f, i, w, a, b));
                lat_q.push_back(ref_lat(f, i, w, a, b));
                acc_cyc = cyc;
                pending = 1'b0;
                sent++;
            end
            @(posedge clk);
        end
        check("rand_completed", 64'(cyc < 20000), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
